// File: rtl/nfv_dc_xfer_pkg.sv
// Shared types and the round-robin pick function for the clock-crossing
// transfer scheduler.
package nfv_dc_xfer_pkg;

  localparam int MAX_REQ   = 16;
  localparam int MAX_IDX_W = 4;

  typedef enum logic [2:0] {
    RESYNC   = 3'd0,
    IDLE     = 3'd1,
    WAIT_ACK = 3'd2,
    ERR      = 3'd3,
    GAP      = 3'd4
  } state_t;

  typedef struct packed {
    logic                 valid;
    logic [MAX_IDX_W-1:0] idx;
  } pick_t;

  // First set bit of req at or above ptr, wrapping modulo n.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0]   req,
                                    input logic [MAX_IDX_W-1:0] ptr,
                                    input int                   n);
    pick_t p;
    int    i;
    p = '0;
    for (int k = 0; k < MAX_REQ; k++) begin
      i = (int'(ptr) + k) % n;
      if (k < n && !p.valid && req[i]) begin
        p.valid = 1'b1;
        p.idx   = MAX_IDX_W'(i);
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/nfv_rr_arb.sv
// Combinational round-robin pick; the priority pointer is owned by the
// scheduler.
module nfv_rr_arb
  import nfv_dc_xfer_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [$clog2(NUM_REQ)-1:0] winner,
  output logic                       valid
);

  localparam int IDX_W = $clog2(NUM_REQ);

  pick_t pick;

  assign pick   = rr_pick(MAX_REQ'(req), MAX_IDX_W'(ptr), NUM_REQ);
  assign winner = IDX_W'(pick.idx);
  assign valid  = pick.valid;

endmodule

// File: rtl/nfv_dc_xfer_sched.sv
// Source-side scheduler sharing one toggle-handshake crossing between
// NUM_REQ requesters, with ack timeout detection.
module nfv_dc_xfer_sched
  import nfv_dc_xfer_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH-1:0]   data_in,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [NUM_REQ-1:0]         done,
  output logic [WIDTH-1:0]           xfer_data,
  output logic                       xfer_req_tgl,
  input  logic                       xfer_ack_tgl_sync,
  output logic [$clog2(NUM_REQ)-1:0] sel_id,
  output logic                       busy,
  output logic                       timeout_err
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_TERM =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  state_t             state, state_d;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   winner;
  logic               win_valid;
  logic               match;
  logic               grant;
  logic               ack_hit;
  logic               timed_out;
  logic [CNT_W-1:0]   cnt;

  nfv_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
    .req    (req),
    .ptr    (ptr),
    .winner (winner),
    .valid  (win_valid)
  );

  // The far side has consumed the current word once its ack toggle catches up.
  assign match = (xfer_ack_tgl_sync == xfer_req_tgl);
  assign busy  = (state != IDLE);

  always_comb begin
    // NOTE: every variable gets a default before the case so no path infers a latch.
    state_d   = state;
    grant     = 1'b0;
    ack_hit   = 1'b0;
    timed_out = 1'b0;
    unique case (state)
      RESYNC: if (match) state_d = IDLE;
      IDLE: begin
        if (win_valid) begin
          grant   = 1'b1;
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        // A match on the terminal-count cycle still completes normally.
        if (match) begin
          ack_hit = 1'b1;
          state_d = GAP;
        end else if (TIMEOUT_CYCLES > 0 && cnt == CNT_TERM) begin
          timed_out = 1'b1;
          state_d   = ERR;
        end
      end
      ERR:     if (match) state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = RESYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= RESYNC;
    else     state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt          <= '0;
      done         <= '0;
      xfer_data    <= '0;
      xfer_req_tgl <= 1'b0;
      sel_id       <= '0;
      timeout_err  <= 1'b0;
      ptr          <= '0;
      cnt          <= '0;
    end else begin
      // NOTE: non-blocking assignments; the pulse defaults below are overridden later in the same block.
      gnt         <= '0;
      done        <= '0;
      timeout_err <= timed_out;
      if (grant) begin
        gnt[winner]  <= 1'b1;
        xfer_data    <= data_in[int'(winner)*WIDTH +: WIDTH];
        sel_id       <= winner;
        xfer_req_tgl <= ~xfer_req_tgl;
        ptr          <= (winner == LAST_IDX) ? '0 : winner + 1'b1;
        cnt          <= '0;
      end else if (state == WAIT_ACK && !match) begin
        cnt <= cnt + 1'b1;
      end
      if (ack_hit) done[sel_id] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_nfv_dc_xfer_sched.sv
// Self-checking bench for nfv_dc_xfer_sched: table-driven transfers, corner
// sequences and a randomized run against a timeline reference model.
module tb_nfv_dc_xfer_sched;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 32;
  localparam int TIMEOUT = 16;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] data_in;
  logic [NUM_REQ-1:0]       gnt;
  logic [NUM_REQ-1:0]       done;
  logic [WIDTH-1:0]         xfer_data;
  logic                     xfer_req_tgl;
  logic                     ack;
  logic [1:0]               sel_id;
  logic                     busy;
  logic                     timeout_err;

  int   ntests = 0;
  int   nfail  = 0;
  logic exp_tgl;

  typedef struct {
    logic [3:0]  req;
    int          idx;
    logic [31:0] word;
    int          delay;
  } vec_t;

  always #5 clk = ~clk;

  nfv_dc_xfer_sched #(
    .NUM_REQ        (NUM_REQ),
    .WIDTH          (WIDTH),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .req               (req),
    .data_in           (data_in),
    .gnt               (gnt),
    .done              (done),
    .xfer_data         (xfer_data),
    .xfer_req_tgl      (xfer_req_tgl),
    .xfer_ack_tgl_sync (ack),
    .sel_id            (sel_id),
    .busy              (busy),
    .timeout_err       (timeout_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete transfer starting with the DUT in IDLE; req stays driven.
  task automatic do_xfer(input vec_t v);
    logic [3:0] oh;
    oh  = 4'b0001 << v.idx;
    req = v.req;
    for (int i = 0; i < NUM_REQ; i++)
      data_in[i*WIDTH +: WIDTH] = (i == v.idx) ? v.word : (~v.word ^ 32'(i));
    step();
    exp_tgl = ~exp_tgl;
    check("gnt", 64'(gnt), 64'(oh));
    check("xfer_data", 64'(xfer_data), 64'(v.word));
    check("xfer_req_tgl", 64'(xfer_req_tgl), 64'(exp_tgl));
    check("sel_id", 64'(sel_id), 64'(v.idx));
    repeat (v.delay) begin
      data_in = {$urandom(), $urandom(), $urandom(), $urandom()};
      step();
      check("wait_ack", {busy, gnt, done, timeout_err, xfer_data}, {1'b1, 9'b0, v.word});
    end
    ack = exp_tgl;
    step();
    check("done", {busy, gnt, done, timeout_err}, {1'b1, 4'b0, oh, 1'b0});
    step();
    check("back_idle", {busy, gnt, done, timeout_err}, 10'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[$];
    vec_t v;
    int   idle_at, ack_at, sel, ptr_m;
    bit   found;
    logic [3:0]  eg, ed;
    logic        eb, etgl;
    logic [31:0] edata;

    vecs.push_back('{4'b0010, 1, 32'hDEAD_BEEF, 5});
    vecs.push_back('{4'b0100, 2, 32'h1000_0001, 3});
    vecs.push_back('{4'b1000, 3, 32'h1000_0002, 3});
    for (int k = 0; k < 8; k++)
      vecs.push_back('{4'b1111, k % 4, 32'hC0DE_0000 + 32'(k), 3});
    vecs.push_back('{4'b0010, 1, 32'h2000_0011, 3});
    vecs.push_back('{4'b0011, 0, 32'h2000_0012, 3});
    vecs.push_back('{4'b1100, 2, 32'h2000_0013, 3});
    vecs.push_back('{4'b1001, 3, 32'h2000_0014, 3});
    vecs.push_back('{4'b1001, 0, 32'h2000_0015, 3});
    vecs.push_back('{4'b0110, 1, 32'h2000_0016, 3});
    vecs.push_back('{4'b0001, 0, 32'h2000_0017, 3});

    // Reset with the far side out of step: stay in RESYNC, never grant.
    rst = 1'b1; ack = 1'b1; req = 4'b1111; data_in = '0;
    step(); step();
    check("reset_pulses", {gnt, done, timeout_err, xfer_req_tgl}, 10'b0);
    check("reset_data", 64'(xfer_data), 64'h0);
    check("reset_sel", 64'(sel_id), 64'h0);
    check("reset_busy", 64'(busy), 64'h1);
    rst = 1'b0;
    repeat (3) begin
      step();
      check("resync_hold", {busy, gnt}, 5'b1_0000);
    end
    req = 4'b0; ack = 1'b0;
    step();
    check("resync_exit", 64'(busy), 64'h0);
    exp_tgl = 1'b0;

    foreach (vecs[n]) do_xfer(vecs[n]);

    // Ack never returns: timeout 16 cycles after the grant, no done.
    req = 4'b0100;
    data_in = {32'h0, 32'h5A5A_0002, 32'h0, 32'h0};
    step();
    exp_tgl = ~exp_tgl;
    check("to_gnt", 64'(gnt), 64'h4);
    req = 4'b0;
    repeat (15) begin
      step();
      check("to_wait", {timeout_err, done}, 5'b0);
    end
    step();
    check("timeout_err", {busy, timeout_err, done}, 6'b11_0000);
    repeat (4) begin
      data_in = {$urandom(), $urandom(), $urandom(), $urandom()};
      step();
      check("err_hold", {busy, timeout_err, done, gnt, xfer_req_tgl, xfer_data},
            {1'b1, 9'b0, exp_tgl, 32'h5A5A_0002});
    end
    ack = exp_tgl;
    step();
    check("err_gap", {busy, done, timeout_err}, 6'b10_0000);
    step();
    check("err_idle", 64'(busy), 64'h0);
    v = '{4'b0011, 0, 32'h3000_0001, 3};
    do_xfer(v);

    // Ack lands on the terminal-count cycle: completes, no error.
    v = '{4'b0010, 1, 32'h3000_0002, 15};
    do_xfer(v);

    // Reset in WAIT_ACK abandons the transfer silently.
    req = 4'b0100;
    data_in = {32'h0, 32'h7777_0002, 32'h0, 32'h0};
    step();
    check("mid_gnt", 64'(gnt), 64'h4);
    req = 4'b0;
    step(); step();
    rst = 1'b1; ack = 1'b0;
    step();
    check("mid_rst", {xfer_req_tgl, xfer_data, gnt, done, timeout_err, sel_id},
          44'h0);
    rst = 1'b0;
    exp_tgl = 1'b0;
    repeat (20) begin
      step();
      check("mid_quiet", {done, timeout_err}, 5'b0);
    end
    v = '{4'b1111, 0, 32'h4000_0000, 2};
    do_xfer(v);

    // Randomized run against a timeline model of the protocol.
    rst = 1'b1; ack = 1'b0; req = 4'b0;
    step();
    rst = 1'b0;
    eg = '0; ed = '0; eb = 1'b1; edata = '0; etgl = 1'b0;
    ptr_m = 0; idle_at = 1; ack_at = -1; sel = 0;
    for (int c = 0; c < 600; c++) begin
      check("rnd_gnt", 64'(gnt), 64'(eg));
      check("rnd_done", 64'(done), 64'(ed));
      check("rnd_busy", 64'(busy), 64'(eb));
      check("rnd_data", 64'(xfer_data), 64'(edata));
      check("rnd_tgl", 64'(xfer_req_tgl), 64'(etgl));
      check("rnd_err", 64'(timeout_err), 64'h0);
      eg = '0; ed = '0;
      data_in = {$urandom(), $urandom(), $urandom(), $urandom()};
      req = ($urandom_range(0, 3) == 0) ? 4'b0 : 4'($urandom_range(1, 15));
      if (ack_at == c) begin
        ack     = etgl;
        ed      = 4'b0001 << sel;
        idle_at = c + 2;
        ack_at  = -1;
      end else if (ack_at < 0 && c >= idle_at && req != 4'b0) begin
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
          if (!found && req[(ptr_m + k) % NUM_REQ]) begin
            found = 1'b1;
            sel   = (ptr_m + k) % NUM_REQ;
          end
        end
        eg      = 4'b0001 << sel;
        edata   = data_in[sel*WIDTH +: WIDTH];
        etgl    = ~etgl;
        ptr_m   = (sel + 1) % NUM_REQ;
        ack_at  = c + 1 + int'($urandom_range(0, 5));
        idle_at = 1 << 30;
      end
      eb = (c + 1 < idle_at);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/nfv_dc_xfer_sched.md
Name: nfv_dc_xfer_sched

Overview:
- Source-domain scheduler that shares one toggle-handshake clock-crossing channel between NUM_REQ requesters.
- Round-robin arbitrates, latches the winner's word into a hold register and toggles the request line, then waits for the returned ack toggle, which the top level passes through an nfv_dc_sync instance clocked by clk.
- Reports per-requester grant and completion, and flags an ack timeout.

Parameters:
- NUM_REQ, 4: number of requesters, 2..16.
- WIDTH, 32: payload width in bits.
- TIMEOUT_CYCLES, 1024: WAIT_ACK cycles before timeout; 0 disables the timeout.
- CNT_W, $clog2(TIMEOUT_CYCLES+1): timeout counter width (derived, not overridden).

Ports:
- clk  in  1  clock; the only clock.
- rst  in  1  synchronous reset, active-high.
- req  in  NUM_REQ  per-requester request level.
- data_in  in  NUM_REQ*WIDTH  requester i's word at bits [i*WIDTH +: WIDTH].
- gnt  out  NUM_REQ  one-hot, 1-cycle pulse; data_in of that requester captured.
- done  out  NUM_REQ  one-hot, 1-cycle pulse; far side acknowledged.
- xfer_data  out  WIDTH  hold register to the far domain; stable while busy.
- xfer_req_tgl  out  1  request toggle to the far domain.
- xfer_ack_tgl_sync  in  1  far-side ack toggle, already synchronised into clk.
- sel_id  out  $clog2(NUM_REQ)  index of the requester in flight.
- busy  out  1  high in every state except IDLE.
- timeout_err  out  1  1-cycle pulse on timeout.

Behaviour:
- Reset values, all registered: state=RESYNC, xfer_req_tgl=0, xfer_data=0, gnt=0, done=0, sel_id=0, timeout_err=0, RR pointer=0, timeout counter=0.
- Match condition: xfer_ack_tgl_sync == xfer_req_tgl.
- RESYNC: wait for match, then go to IDLE. This covers a far side that leaves reset later. busy=1.
- IDLE: if any req bit is set, the winner is the first set bit searching from the pointer upward, modulo NUM_REQ.
- Grant edge (registered):
  - gnt[winner]=1.
  - xfer_data <= data_in of the winner; sel_id <= winner.
  - xfer_req_tgl flips.
  - pointer <= (winner+1) mod NUM_REQ.
  - counter cleared; state -> WAIT_ACK.
- Grant latency: req seen in IDLE on cycle N gives gnt high on cycle N+1. The requester holds req/data until gnt. A req dropped before gnt is simply not serviced.
- WAIT_ACK:
  - On match: done[sel_id]=1 on the next cycle, state -> GAP.
  - Otherwise the counter increments. When counter == TIMEOUT_CYCLES-1 with no match (TIMEOUT_CYCLES>0): timeout_err=1 on the next cycle, state -> ERR.
  - If match and the terminal count occur on the same cycle, match wins: done is pulsed, no error.
- ERR: xfer_data and xfer_req_tgl are held. Wait for match, then go to GAP. No done pulse is ever issued for that transfer.
- GAP: exactly one cycle, then IDLE. This guarantees at least 1 idle cycle between transfers and that gnt never pulses back-to-back.
- Throughput: at most one transfer in flight. The minimum grant-to-grant period is 3 cycles plus the ack round trip.
- xfer_data and xfer_req_tgl change only on a grant edge or on reset.
- Pointer wrap: after granting requester NUM_REQ-1, the pointer returns to 0.
- Fairness: a requester holding req continuously waits at most NUM_REQ-1 other grants.
- Reset asserted mid-transfer: everything returns to reset values on the next edge; the block re-enters RESYNC. An in-flight transfer is abandoned with no done or timeout pulse.
- A req set for an index whose transfer is in flight is treated as a new request; it becomes eligible once the block is back in IDLE.

Decomposition:
- Package nfv_dc_xfer_pkg:
  - state enum {RESYNC, IDLE, WAIT_ACK, ERR, GAP}, 3-bit encoding.
  - Function rr_pick(req, ptr) returning winner index and a valid flag.
- Sub-module nfv_rr_arb: combinational round-robin pick, parameterised by NUM_REQ. The pointer register lives in the scheduler.
- The ack synchroniser stays outside the block; the top level instantiates nfv_dc_sync on the far ack toggle.

Test Plan:
- Reset with ack_sync=1 -> busy=1 and state stays RESYNC. Ack_sync driven to 0 -> IDLE next cycle; no gnt issued before that point.
- req=4'b0010, data_in[1]=32'hDEAD_BEEF -> gnt=4'b0010 one cycle later, xfer_data=DEADBEEF, xfer_req_tgl 0->1. Ack_sync driven to 1 after 5 cycles -> done=4'b0010 one cycle after the match.
- req=4'b1111 held for 8 transfers with 3-cycle ack echo -> grant order 0,1,2,3,0,1,2,3 and at least 1 GAP cycle between gnt pulses.
- TIMEOUT_CYCLES=16, ack never toggles -> timeout_err pulses once, 16 cycles after gnt, with no done. Ack toggling later -> GAP then IDLE; the next req is granted normally.
- Ack match on the same cycle as the terminal count -> done pulses and timeout_err stays 0.
- rst asserted in WAIT_ACK -> next edge gives xfer_req_tgl=0, xfer_data=0, pointer=0, and no done or timeout_err pulse.
